piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in serial-out transmitter that sits directly upstream of the 8-bit serial-in shift register. It accepts parallel words over a valid/ready handshake and emits one bit per `clk` with a valid qualifier and a last-bit strobe. Its one-word holding buffer lets consecutive words stream with no idle cycle between them. The downstream register uses the first-arriving bit as bit 0, so the default bit order is LSB first.

## Interface
Parameters:
- `WIDTH`, default 8: word width in bits; must be at least 2.
- `LSB_FIRST`, default 1: 1 shifts out bit 0 first; 0 shifts out bit WIDTH-1 first.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `clr`, in, 1: reset, synchronous and active-high.
- `din`, in, WIDTH: parallel word.
- `din_valid`, in, 1: `din` is valid.
- `din_ready`, out, 1: block can accept a word this cycle.
- `sdata`, out, 1: serial bit; forced to 0 when `sdata_valid` is 0.
- `sdata_valid`, out, 1: `sdata` carries a payload bit this cycle.
- `sdata_last`, out, 1: current bit is the final bit of a word.
- `busy`, out, 1: a word is shifting or held.

## Operation
- Transfer: a word is accepted on a rising edge where `din_valid && din_ready`.
- Storage:
  - `shreg` is a WIDTH-bit shift register.
  - `cnt` is a bit counter of width $clog2(WIDTH).
  - `hold` is a one-word buffer with a `hold_full` flag.
- States:
  - IDLE: no word in flight.
  - SHIFT: `shreg` is being emitted.
- Load point: the cycle in state IDLE, or the cycle in SHIFT with `cnt == WIDTH-1`.
  - If `hold_full`, `shreg` loads from `hold` and `hold_full` clears.
  - Else, if a transfer occurs, `shreg` loads from `din`.
  - Else, the state goes to IDLE.
  - Any load sets state SHIFT and `cnt = 0`.
- Non-load SHIFT cycle:
  - `cnt` increments.
  - `shreg` shifts toward the output end, filling with 0.
  - A transfer in this cycle writes `hold` and sets `hold_full`.
- `din_ready = ~hold_full && ~clr`.
  - `hold` is always empty in IDLE, so IDLE accepts go straight to `shreg`.
- Output bit:
  - `sdata = shreg[0]` when LSB_FIRST=1.
  - `sdata = shreg[WIDTH-1]` when LSB_FIRST=0.
- Strobes:
  - `sdata_valid = (state == SHIFT)`.
  - `sdata_last = (state == SHIFT) && (cnt == WIDTH-1)`.
  - `busy = (state == SHIFT) || hold_full`.
- Boundary cases:
  - Hold full during SHIFT: `din_ready` is 0; upstream stalls and the word is not lost.
  - Last bit with hold empty and `din_valid` high: direct load, so the next word follows gap-free.
  - Last bit with hold full: `hold` moves to `shreg` and `din_ready` returns to 1 in the next cycle.
  - `din` changing while `din_ready` is low: ignored.
  - `clr` mid-word: the partial word is abandoned, `hold` is discarded, and no further `sdata_valid` is emitted.

## Timing
- Reset: after any edge with `clr = 1`:
  - state IDLE, `cnt = 0`, `shreg = 0`, `hold = 0`, `hold_full = 0`;
  - `sdata = 0`, `sdata_valid = 0`, `sdata_last = 0`, `busy = 0`;
  - `din_ready = 1` once `clr` is low. `din_ready` is 0 throughout the reset cycle.
- Latency: a word accepted at edge k presents its first bit in the cycle after edge k.
  - Each bit is held for exactly one cycle.
  - `sdata_last` is high in the cycle after edge k+WIDTH-1.
- Throughput: one word per WIDTH cycles sustained, with no bubble when upstream keeps `din_valid` asserted.
- Downstream capture: the downstream register samples `sdata` on the same `clk` edge, gated by `sdata_valid`. A word is complete in that register on the edge that ends the `sdata_last` cycle.
- Combinational paths: `din_ready` is the only combinational output. It depends only on registered `hold_full` and on `clr`, with no path from `din_valid`.

## Structure
- Shared package `piso_pkg` holds:
  - the state enum {IDLE, SHIFT};
  - the default word-width constant (8), also used by the shift-register stage.
- Single module; no sub-module. The hold buffer and the shifter are each too small to justify a separate instance.

## Test plan
- Single word: reset, then `din = 8'hA5` for one cycle.
  - `sdata` sequence over the next 8 cycles is 1,0,1,0,0,1,0,1 with `sdata_valid` high throughout.
  - `sdata_last` is high only on the 8th bit.
  - The downstream register reads 8'hA5.
- Back-to-back: `8'h3C` then `8'hC3`, with `din_valid` held high.
  - 16 contiguous valid cycles.
  - `sdata_last` on bits 8 and 16.
  - `din_ready` is low from the cycle after the second accept until the load at bit 8.
- Stall: offer three words continuously.
  - The third waits with `din_ready = 0` until the first word's last bit.
  - All 24 bits arrive in order with no gaps.
- Idle gap: a word, then 5 idle cycles, then `8'hFF`.
  - `sdata_valid` and `sdata` are 0 during the gap.
  - `busy` is 0 during the gap.
- Reset mid-word: `clr` asserted on bit 4 of `8'h5A` while `hold` contains `8'h81`.
  - Next cycle: `sdata_valid = 0` and `busy = 0`.
  - `8'h81` is never emitted.
- `LSB_FIRST = 0`: `8'hA5` emits 1,0,1,0,0,1,0,1 MSB first; `8'h01` emits seven 0s then a 1.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out transmitter
// and the downstream shift-register stage.
package piso_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam int unsigned PISO_WIDTH = 8;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word holding buffer so that
// consecutive words stream out back to back.
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_WIDTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdata,
  output logic             sdata_valid,
  output logic             sdata_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             xfer;
  logic             load_pt;
  logic [WIDTH-1:0] shreg_next;

  // Ready never looks at din_valid, so upstream sees no combinational loop.
  assign din_ready  = ~hold_full & ~clr;
  assign xfer       = din_valid & din_ready;
  assign load_pt    = (state == IDLE) || (cnt == LAST);
  assign shreg_next = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (load_pt) begin
      if (hold_full) begin
        shreg     <= hold;
        hold_full <= 1'b0;
        state     <= SHIFT;
        cnt       <= '0;
      end else if (xfer) begin
        shreg <= din;
        state <= SHIFT;
        cnt   <= '0;
      end else begin
        state <= IDLE;
      end
    end else begin
      cnt   <= cnt + CW'(1);
      shreg <= shreg_next;
      if (xfer) begin
        hold      <= din;
        hold_full <= 1'b1;
      end
    end
  end

  always_comb begin
    sdata_valid = (state == SHIFT);
    sdata_last  = sdata_valid && (cnt == LAST);
    sdata       = sdata_valid & (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
    busy        = sdata_valid | hold_full;
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: LSB-first and MSB-first instances share stimulus.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       clr;
  logic       din_valid;
  logic [7:0] din;

  logic din_ready, sdata, sdata_valid, sdata_last, busy;
  logic m_ready, m_sdata, m_valid, m_last, m_busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned w0, w1, w2;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut (
    .clk        (clk),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sdata      (sdata),
    .sdata_valid(sdata_valid),
    .sdata_last (sdata_last),
    .busy       (busy)
  );

  piso_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk        (clk),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (m_ready),
    .sdata      (m_sdata),
    .sdata_valid(m_valid),
    .sdata_last (m_last),
    .busy       (m_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word until accepted; din is scrambled while ready is low.
  task automatic send(input logic [7:0] w, output int unsigned waits);
    logic acc;
    acc       = 1'b0;
    waits     = 0;
    din_valid = 1'b1;
    for (int unsigned t = 0; t < 64; t++) begin
      if (din_ready) begin
        din = w;
        acc = 1'b1;
      end else begin
        din = 8'($urandom);
      end
      step();
      if (acc) break;
      waits++;
    end
    din_valid = 1'b0;
    check("send_accept", {31'd0, acc}, 32'd1);
  endtask

  // Called in the cycle showing bit 0; checks 8 bits on both instances.
  task automatic expect_word(input string tag, input logic [7:0] w, input logic [7:0] rdy);
    logic [7:0] rx, rxm;
    logic       last_e;
    rx  = '0;
    rxm = '0;
    for (int i = 0; i < 8; i++) begin
      last_e = (i == 7);
      check($sformatf("%s_lsb%0d", tag, i), {28'd0, sdata_valid, sdata, sdata_last, busy},
            {28'd0, 1'b1, w[i], last_e, 1'b1});
      check($sformatf("%s_msb%0d", tag, i), {29'd0, m_valid, m_sdata, m_last},
            {29'd0, 1'b1, w[7-i], last_e});
      check($sformatf("%s_rdy%0d", tag, i), {31'd0, din_ready}, {31'd0, rdy[i]});
      if (sdata_valid) rx = {sdata, rx[7:1]};
      if (m_valid) rxm = {rxm[6:0], m_sdata};
      step();
    end
    check($sformatf("%s_rx_lsb", tag), {24'd0, rx}, {24'd0, w});
    check($sformatf("%s_rx_msb", tag), {24'd0, rxm}, {24'd0, w});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    clr       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    step();
    step();
    check("rst_out", {26'd0, busy, sdata_valid, sdata, sdata_last, m_busy, m_valid}, 32'd0);
    check("rst_ready", {31'd0, din_ready}, 32'd0);
    clr = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, din_ready}, 32'd1);

    // Single word
    din = 8'hA5;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    expect_word("a5", 8'hA5, 8'hFF);
    check("a5_idle", {29'd0, sdata_valid, busy, sdata}, 32'd0);

    // Back to back
    fork
      begin send(8'h3C, w0); send(8'hC3, w1); end
      begin step(); expect_word("b2b0", 8'h3C, 8'h01); expect_word("b2b1", 8'hC3, 8'hFF); end
    join
    check("b2b_waits", w0 + w1, 32'd0);
    check("b2b_idle", {30'd0, sdata_valid, busy}, 32'd0);

    // Stall with three words offered continuously
    fork
      begin send(8'h96, w0); send(8'h0F, w1); send(8'hE1, w2); end
      begin
        step();
        expect_word("st0", 8'h96, 8'h01);
        expect_word("st1", 8'h0F, 8'h01);
        expect_word("st2", 8'hE1, 8'hFF);
      end
    join
    check("stall_waits01", w0 + w1, 32'd0);
    check("stall_waits2", w2, 32'd7);

    // Idle gap
    din = 8'h66;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    expect_word("gapw", 8'h66, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("gap%0d", i), {26'd0, sdata_valid, sdata, sdata_last, busy, m_valid, m_sdata}, 32'd0);
      if (i == 4) begin
        din = 8'hFF;
        din_valid = 1'b1;
      end
      step();
    end
    din_valid = 1'b0;
    expect_word("ff", 8'hFF, 8'hFF);

    // Reset mid-word with a word held
    din = 8'h5A;
    din_valid = 1'b1;
    step();
    din = 8'h81;
    step();
    din_valid = 1'b0;
    check("mid_b1", {30'd0, sdata, busy}, 32'h3);
    check("mid_held", {31'd0, din_ready}, 32'd0);
    step();
    check("mid_b2", {30'd0, sdata, sdata_valid}, 32'h1);
    step();
    check("mid_b3", {30'd0, sdata, sdata_valid}, 32'h3);
    clr = 1'b1;
    #1;
    check("mid_clr_ready", {31'd0, din_ready}, 32'd0);
    step();
    clr = 1'b0;
    #1;
    check("mid_ready_back", {31'd0, din_ready}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("post_clr%0d", i), {27'd0, sdata_valid, busy, sdata, m_valid, m_busy}, 32'd0);
      step();
    end

    // 8'h01: LSB instance emits 1 then zeros, MSB instance seven zeros then 1
    din = 8'h01;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    expect_word("w01", 8'h01, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
